// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the 65C02 external-bus responder.
// Holds the FSM state encodings, vector addresses and the region decode helper.
package cpu65_bus_pkg;

  typedef logic [1:0] resp_state_t;

  localparam resp_state_t IDLE = 2'd0;
  localparam resp_state_t WAIT = 2'd1;
  localparam resp_state_t ACK  = 2'd2;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_ROM  = 2'd1,
    REG_NONE = 2'd2
  } region_t;

  // RAM is checked first so it wins whenever the two windows overlap.
  function automatic region_t decode_region(input logic [15:0] a,
                                            input int unsigned ram_aw,
                                            input logic [15:0] rom_base);
    if ((a >> ram_aw) == 16'd0)
      return REG_RAM;
    else if (a >= rom_base)
      return REG_ROM;
    else
      return REG_NONE;
  endfunction

  function automatic logic is_vector(input logic [15:0] a);
    return (a >= VEC_NMI);
  endfunction

endpackage

// File: rtl/bus_responder_ram.sv
// Single-port synchronous RAM, byte wide, with a registered read port.
// Contents have no reset so a CPU reset never disturbs memory.
module bus_responder_ram #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the 65C02 external bus: RAM, vector ROM,
// wait-state generation, opcode counting and bus error pulses.
module bus_responder
  import cpu65_bus_pkg::*;
#(
  parameter int unsigned RAM_AW   = 12,
  parameter logic [15:0] ROM_BASE = 16'hF000,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned ROM_WAIT = 1,
  parameter logic [15:0] NMI_VEC  = 16'hE100,
  parameter logic [15:0] RST_VEC  = 16'hE000,
  parameter logic [15:0] IRQ_VEC  = 16'hE200
) (
  input  logic        mem_clk,
  input  logic        resb,
  input  logic        bus_valid,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rwb,
  input  logic        sync,
  input  logic        vpb,
  input  logic        mlb,
  output logic        rdy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        lock_active,
  output logic [15:0] opcode_count,
  output logic        err_wp,
  output logic        err_vec,
  output logic        err_unmapped
);

  resp_state_t state;
  logic [2:0]  cnt;
  logic [15:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic        lat_rwb;
  logic        lat_sync;
  logic        lat_vpb;

  region_t     in_region;
  region_t     lat_region;
  logic [2:0]  in_wait;
  logic        in_vec_err;
  logic        lat_vec_err;
  logic        accept;
  logic        wait_done;

  logic                ram_we;
  logic [RAM_AW-1:0]   ram_addr;
  logic [7:0]          ram_wdata;
  logic [7:0]          ram_q;
  logic [7:0]          rom_byte;

  assign in_region   = decode_region(addr, RAM_AW, ROM_BASE);
  assign lat_region  = decode_region(lat_addr, RAM_AW, ROM_BASE);
  assign in_vec_err  = !vpb && !is_vector(addr);
  assign lat_vec_err = !lat_vpb && !is_vector(lat_addr);
  assign accept      = bus_valid && (state != WAIT);
  assign wait_done   = (state == WAIT) && (cnt == 3'd1);

  always_comb begin
    in_wait = 3'd0;
    case (in_region)
      REG_RAM: in_wait = RAM_WAIT[2:0];
      REG_ROM: in_wait = ROM_WAIT[2:0];
      default: in_wait = 3'd0;
    endcase
  end

  // The RAM sees the live bus address when a 0-wait request is accepted and the
  // latched address while waiting, so its registered read lands exactly in ACK.
  assign ram_addr  = (state == WAIT) ? lat_addr[RAM_AW-1:0] : addr[RAM_AW-1:0];
  assign ram_wdata = (state == WAIT) ? lat_wdata : wdata;
  assign ram_we    = resb &&
                     ((accept && (in_wait == 3'd0) && (in_region == REG_RAM) &&
                       !rwb && !in_vec_err) ||
                      (wait_done && (lat_region == REG_RAM) && !lat_rwb && !lat_vec_err));

  bus_responder_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk   (mem_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge mem_clk or negedge resb) begin
    if (!resb) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      cnt       <= 3'd0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 8'h00;
      lat_rwb   <= 1'b1;
      lat_sync  <= 1'b0;
      lat_vpb   <= 1'b1;
    end else begin
      case (state)
        WAIT: begin
          if (cnt == 3'd1) begin
            state <= ACK;
            rdy   <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          if (bus_valid) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_rwb   <= rwb;
            lat_sync  <= sync;
            lat_vpb   <= vpb;
            if (in_wait == 3'd0) begin
              state <= ACK;
            end else begin
              state <= WAIT;
              rdy   <= 1'b0;
              cnt   <= in_wait;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Opcode fetches are counted as their ACK clock ends; the count saturates.
  always_ff @(posedge mem_clk or negedge resb) begin
    if (!resb) begin
      opcode_count <= 16'h0000;
      lock_active  <= 1'b0;
    end else begin
      if ((state == ACK) && lat_rwb && lat_sync && (opcode_count != 16'hFFFF))
        opcode_count <= opcode_count + 16'h0001;
      if (accept)
        lock_active <= !mlb;
    end
  end

  always_comb begin
    rom_byte = 8'hEA;
    case (lat_addr)
      VEC_NMI:          rom_byte = NMI_VEC[7:0];
      VEC_NMI + 16'd1:  rom_byte = NMI_VEC[15:8];
      VEC_RST:          rom_byte = RST_VEC[7:0];
      VEC_RST + 16'd1:  rom_byte = RST_VEC[15:8];
      VEC_IRQ:          rom_byte = IRQ_VEC[7:0];
      VEC_IRQ + 16'd1:  rom_byte = IRQ_VEC[15:8];
      default:          rom_byte = 8'hEA;
    endcase
  end

  assign ack = (state == ACK);

  always_comb begin
    rdata = 8'h00;
    if (ack && lat_rwb) begin
      if (lat_vec_err) begin
        rdata = 8'hFF;
      end else begin
        case (lat_region)
          REG_RAM: rdata = ram_q;
          REG_ROM: rdata = rom_byte;
          default: rdata = 8'hFF;
        endcase
      end
    end
  end

  assign err_wp       = ack && (lat_region == REG_ROM) && !lat_rwb;
  assign err_unmapped = ack && (lat_region == REG_NONE);
  assign err_vec      = ack && lat_vec_err;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: timing, region decode, vectors, errors,
// back-to-back fetches, lock tracking and reset abort behaviour.
module tb_bus_responder;

  logic        mem_clk = 1'b0;
  logic        resb = 1'b0;
  logic        bus_valid = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        rwb = 1'b1;
  logic        sync = 1'b0;
  logic        vpb = 1'b1;
  logic        mlb = 1'b1;
  logic        rdy;
  logic        ack;
  logic [7:0]  rdata;
  logic        lock_active;
  logic [15:0] opcode_count;
  logic        err_wp;
  logic        err_vec;
  logic        err_unmapped;

  int compared = 0;
  int mismatched = 0;

  int         s_lat;
  int         s_lows;
  logic       s_ack;
  logic [7:0] s_rdata;
  logic [2:0] s_err;

  bus_responder dut (
    .mem_clk      (mem_clk),
    .resb         (resb),
    .bus_valid    (bus_valid),
    .addr         (addr),
    .wdata        (wdata),
    .rwb          (rwb),
    .sync         (sync),
    .vpb          (vpb),
    .mlb          (mlb),
    .rdy          (rdy),
    .ack          (ack),
    .rdata        (rdata),
    .lock_active  (lock_active),
    .opcode_count (opcode_count),
    .err_wp       (err_wp),
    .err_vec      (err_vec),
    .err_unmapped (err_unmapped)
  );

  always #5 mem_clk = ~mem_clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one request, then waits (bounded) for ack and snapshots the result.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                               input logic r, input logic s, input logic v,
                               input logic m);
    addr = a; wdata = d; rwb = r; sync = s; vpb = v; mlb = m; bus_valid = 1'b1;
    @(posedge mem_clk); #1;
    bus_valid = 1'b0; rwb = 1'b1; sync = 1'b0; vpb = 1'b1; mlb = 1'b1;
    s_lat = 1;
    s_lows = 0;
    while (ack !== 1'b1 && s_lat < 20) begin
      if (rdy === 1'b0) s_lows++;
      @(posedge mem_clk); #1;
      s_lat++;
    end
    s_ack   = ack;
    s_rdata = rdata;
    s_err   = {err_wp, err_vec, err_unmapped};
  endtask

  initial begin
    int acks;
    logic [7:0] first_data;

    #12;
    checkOutput("reset_rdy", rdy, 1);
    checkOutput("reset_ack", ack, 0);
    checkOutput("reset_rdata", rdata, 8'h00);
    checkOutput("reset_lock", lock_active, 0);
    checkOutput("reset_count", opcode_count, 16'h0000);
    checkOutput("reset_err", {err_wp, err_vec, err_unmapped}, 3'b000);
    @(negedge mem_clk);
    resb = 1'b1;
    @(posedge mem_clk); #1;

    // RAM with no wait states
    applyStimulus(16'h0123, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("ram_wr_ack", s_ack, 1);
    checkOutput("ram_wr_lat", s_lat, 1);
    checkOutput("ram_wr_rdy", rdy, 1);
    applyStimulus(16'h0123, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("ram_rd_lat", s_lat, 1);
    checkOutput("ram_rd_lows", s_lows, 0);
    checkOutput("ram_rd_data", s_rdata, 8'h5A);

    // Vector pulls through the 1-wait ROM
    applyStimulus(16'hFFFC, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("vec_lo_lat", s_lat, 2);
    checkOutput("vec_lo_lows", s_lows, 1);
    checkOutput("vec_lo_data", s_rdata, 8'h00);
    checkOutput("vec_lo_err", s_err, 3'b000);
    applyStimulus(16'hFFFD, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("vec_hi_lows", s_lows, 1);
    checkOutput("vec_hi_data", s_rdata, 8'hE0);

    // Error cases
    applyStimulus(16'hF800, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("wp_lat", s_lat, 2);
    checkOutput("wp_err", s_err, 3'b100);
    checkOutput("wp_data", s_rdata, 8'h00);
    applyStimulus(16'h8000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("unm_lat", s_lat, 1);
    checkOutput("unm_data", s_rdata, 8'hFF);
    checkOutput("unm_err", s_err, 3'b001);
    applyStimulus(16'h0200, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("vecerr_data", s_rdata, 8'hFF);
    checkOutput("vecerr_err", s_err, 3'b010);
    @(posedge mem_clk); #1;
    checkOutput("idle_ack", ack, 0);
    checkOutput("idle_err", {err_wp, err_vec, err_unmapped}, 3'b000);

    // Other ROM contents
    applyStimulus(16'hF123, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("rom_fill", s_rdata, 8'hEA);
    applyStimulus(16'hFFFB, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("nmi_hi", s_rdata, 8'hE1);
    applyStimulus(16'hFFFE, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("irq_lo", s_rdata, 8'h00);
    applyStimulus(16'hFFFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("irq_hi", s_rdata, 8'hE2);
    @(posedge mem_clk); #1;
    checkOutput("count_before", opcode_count, 16'h0000);

    // Back-to-back opcode fetches with bus_valid held high
    acks = 0;
    first_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      addr = 16'h0123 + 16'(i); rwb = 1'b1; sync = 1'b1; vpb = 1'b1; bus_valid = 1'b1;
      @(posedge mem_clk); #1;
      if (ack === 1'b1) acks++;
      if (i == 0) first_data = rdata;
      checkOutput("b2b_rdy", rdy, 1);
    end
    bus_valid = 1'b0; sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge mem_clk); #1;
      if (ack === 1'b1) acks++;
    end
    checkOutput("b2b_acks", acks, 4);
    checkOutput("b2b_first", first_data, 8'h5A);
    checkOutput("b2b_count", opcode_count, 16'h0004);

    // Locked read-modify-write
    applyStimulus(16'h0010, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("lock_rd", lock_active, 1);
    applyStimulus(16'h0010, 8'hAB, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("lock_wr", lock_active, 1);
    applyStimulus(16'h0010, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("unlock", lock_active, 0);
    checkOutput("rmw_data", s_rdata, 8'hAB);

    // Reset aborting a write that is being accepted
    applyStimulus(16'h0040, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1);
    addr = 16'h0040; wdata = 8'h77; rwb = 1'b0; bus_valid = 1'b1;
    #2;
    resb = 1'b0;
    @(posedge mem_clk); #1;
    checkOutput("abort_rdy", rdy, 1);
    checkOutput("abort_ack", ack, 0);
    checkOutput("abort_count", opcode_count, 16'h0000);
    bus_valid = 1'b0; rwb = 1'b1;
    #2;
    resb = 1'b1;
    @(posedge mem_clk); #1;
    checkOutput("abort_noack", ack, 0);
    applyStimulus(16'h0040, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("abort_mem", s_rdata, 8'h33);

    // Reset in the middle of a wait state
    @(posedge mem_clk); #1;
    addr = 16'hFFFC; rwb = 1'b1; vpb = 1'b0; bus_valid = 1'b1;
    @(posedge mem_clk); #1;
    bus_valid = 1'b0; vpb = 1'b1;
    checkOutput("midwait_rdy_low", rdy, 0);
    resb = 1'b0;
    #1;
    checkOutput("midwait_rdy", rdy, 1);
    checkOutput("midwait_ack", ack, 0);
    #1;
    resb = 1'b1;
    @(posedge mem_clk); #1;
    checkOutput("midwait_noack", ack, 0);
    applyStimulus(16'h0123, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("ram_kept", s_rdata, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
